// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared types, constants and helpers for the board input conditioner
//
// Contents:
//   SYNC_STAGES     number of flops in each input synchroniser
//   repeat_state_t  per-button auto-repeat FSM states
//   tick_period()   clock cycles per debounce sample tick
package board_io_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  function automatic int tick_period(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounce, edge pulses and auto-repeat for one synchronised button
//
// Ports:
//   clock_50        system clock
//   resetn          asynchronous active-low reset
//   i_sample_tick   one-cycle debounce sample strobe shared by all buttons
//   i_sync_pressed  synchronised button, 1 = pressed
//   o_level         debounced level, 1 = pressed
//   o_pressed       one-cycle pulse in the first cycle of a pressed level
//   o_released      one-cycle pulse in the first cycle of a released level
//   o_repeat        one-cycle auto-repeat pulse while held
module button_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES   = 4,
  parameter int REPEAT_EN          = 1,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic clock_50,
  input  logic resetn,
  input  logic i_sample_tick,
  input  logic i_sync_pressed,
  output logic o_level,
  output logic o_pressed,
  output logic o_released,
  output logic o_repeat
);

  localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int CW      = $clog2(RPT_MAX) + 1;

  logic [DEBOUNCE_SAMPLES-1:0] r_hist;
  logic [DEBOUNCE_SAMPLES-1:0] w_hist_next;
  logic                        r_level;
  logic                        w_level_next;
  logic                        r_pressed;
  logic                        r_released;
  logic                        r_repeat;
  logic                        w_repeat_next;
  repeat_state_t               r_state;
  repeat_state_t               w_state_next;
  logic [CW-1:0]               r_rpt_cnt;
  logic [CW-1:0]               w_rpt_cnt_next;

  // Level only moves once the whole sample window agrees; a mixed window holds.
  always_comb begin
    w_hist_next  = r_hist;
    w_level_next = r_level;
    if (i_sample_tick) begin
      w_hist_next = {r_hist[DEBOUNCE_SAMPLES-2:0], i_sync_pressed};
      if (&w_hist_next) begin
        w_level_next = 1'b1;
      end else if (~|w_hist_next) begin
        w_level_next = 1'b0;
      end
    end
  end

  // The FSM looks at the next level, so the tick that releases the button
  // also kills any repeat that would have fired on it.
  always_comb begin
    w_state_next   = r_state;
    w_rpt_cnt_next = r_rpt_cnt;
    w_repeat_next  = 1'b0;
    if ((REPEAT_EN == 0) || !w_level_next) begin
      w_state_next   = IDLE;
      w_rpt_cnt_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next   = DELAY;
          w_rpt_cnt_next = CW'(REPEAT_DELAY_TICKS);
        end
        DELAY, REPEAT: begin
          if (i_sample_tick) begin
            if (r_rpt_cnt <= CW'(1)) begin
              w_repeat_next  = 1'b1;
              w_rpt_cnt_next = CW'(REPEAT_RATE_TICKS);
              w_state_next   = REPEAT;
            end else begin
              w_rpt_cnt_next = r_rpt_cnt - CW'(1);
            end
          end
        end
        default: begin
          w_state_next   = IDLE;
          w_rpt_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      r_hist     <= '0;
      r_level    <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_repeat   <= 1'b0;
      r_state    <= IDLE;
      r_rpt_cnt  <= '0;
    end else begin
      r_hist     <= w_hist_next;
      r_level    <= w_level_next;
      r_pressed  <= w_level_next & ~r_level;
      r_released <= ~w_level_next & r_level;
      r_repeat   <= w_repeat_next;
      r_state    <= w_state_next;
      r_rpt_cnt  <= w_rpt_cnt_next;
    end
  end

  assign o_level    = r_level;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;
  assign o_repeat   = r_repeat;

endmodule

// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - synchronise, debounce and pulse-encode board buttons and switches
//
// Ports:
//   clock_50         system clock
//   resetn           asynchronous active-low reset
//   push_button_n    raw active-low buttons, asynchronous
//   switch           raw slide switches, asynchronous
//   sample_tick      one-cycle pulse every TICK_PERIOD cycles
//   button_level     debounced level, 1 = pressed
//   button_pressed   one-cycle pulse on debounced press
//   button_released  one-cycle pulse on debounced release
//   button_repeat    one-cycle auto-repeat pulse while held
//   switch_sync      synchronised switch levels
//   switch_changed   one-cycle pulse aligned with a switch_sync change
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int NUM_BUTTONS        = 4,
  parameter int NUM_SWITCHES       = 18,
  parameter int CLK_FREQ_HZ        = 50000000,
  parameter int SAMPLE_HZ          = 1000,
  parameter int DEBOUNCE_SAMPLES   = 4,
  parameter int REPEAT_EN          = 1,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic                    clock_50,
  input  logic                    resetn,
  input  logic [NUM_BUTTONS-1:0]  push_button_n,
  input  logic [NUM_SWITCHES-1:0] switch,
  output logic                    sample_tick,
  output logic [NUM_BUTTONS-1:0]  button_level,
  output logic [NUM_BUTTONS-1:0]  button_pressed,
  output logic [NUM_BUTTONS-1:0]  button_released,
  output logic [NUM_BUTTONS-1:0]  button_repeat,
  output logic [NUM_SWITCHES-1:0] switch_sync,
  output logic [NUM_SWITCHES-1:0] switch_changed
);

  localparam int TICK_PERIOD = tick_period(CLK_FREQ_HZ, SAMPLE_HZ);
  localparam int TW          = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  if (TICK_PERIOD < 2 || (CLK_FREQ_HZ % SAMPLE_HZ) != 0) begin : g_bad_tick
    $error("board_input_conditioner: CLK_FREQ_HZ/SAMPLE_HZ must be an integer >= 2");
  end
  if (DEBOUNCE_SAMPLES < 2) begin : g_bad_debounce
    $error("board_input_conditioner: DEBOUNCE_SAMPLES must be >= 2");
  end

  logic [TW-1:0]           r_tick_cnt;
  logic                    w_sample_tick;
  logic [NUM_BUTTONS-1:0]  r_btn_sync [SYNC_STAGES];
  logic [NUM_SWITCHES-1:0] r_sw_sync  [SYNC_STAGES];
  logic [NUM_SWITCHES-1:0] r_sw_out;
  logic [NUM_SWITCHES-1:0] r_sw_chg;
  logic [NUM_BUTTONS-1:0]  w_btn_pressed;

  assign w_sample_tick = (r_tick_cnt == TW'(TICK_PERIOD - 1));

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt <= '0;
    end else if (w_sample_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Button synchronisers reset to 1 so a reset reads as "released".
  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_btn_sync[s] <= '1;
        r_sw_sync[s]  <= '0;
      end
      r_sw_out <= '0;
      r_sw_chg <= '0;
    end else begin
      r_btn_sync[0] <= push_button_n;
      r_sw_sync[0]  <= switch;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_btn_sync[s] <= r_btn_sync[s-1];
        r_sw_sync[s]  <= r_sw_sync[s-1];
      end
      // Extra output stage keeps switch_changed aligned with the new level.
      r_sw_out <= r_sw_sync[SYNC_STAGES-1];
      r_sw_chg <= r_sw_sync[SYNC_STAGES-1] ^ r_sw_out;
    end
  end

  assign w_btn_pressed = ~r_btn_sync[SYNC_STAGES-1];

  genvar g;
  for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_SAMPLES  (DEBOUNCE_SAMPLES),
      .REPEAT_EN         (REPEAT_EN),
      .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS)
    ) u_btn (
      .clock_50      (clock_50),
      .resetn        (resetn),
      .i_sample_tick (w_sample_tick),
      .i_sync_pressed(w_btn_pressed[g]),
      .o_level       (button_level[g]),
      .o_pressed     (button_pressed[g]),
      .o_released    (button_released[g]),
      .o_repeat      (button_repeat[g])
    );
  end

  assign sample_tick    = w_sample_tick;
  assign switch_sync    = r_sw_out;
  assign switch_changed = r_sw_chg;

endmodule
